det_matrix_loader: RTL and testbench

- Upstream stage of the 5x5 determinant unit, `mod_det_5x5`.
- Accepts 25 matrix elements serially over a valid/ready stream, in row-major order (a..y).
- Holds the assembled matrix stable on a flat bus while the combinational determinant settles for a fixed number of cycles.
- Captures the 8-bit determinant and presents it on a valid/ready output handshake. It is the serial-bus front end of the coprocessor's determinant path.

---
 rtl/det_pkg.sv | 18 +
 rtl/det_settle_timer.sv | 34 +++
 rtl/det_matrix_loader.sv | 105 ++++++++++
 tb/tb_det_matrix_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared constants, state encoding and sizing helper for the determinant loader path.
package det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N      = 5;
  localparam int ELEMS      = DEF_N * DEF_N;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  function automatic int idx_w(input int elems);
    return (elems <= 1) ? 1 : $clog2(elems);
  endfunction

endpackage

// File: rtl/det_settle_timer.sv
// 4-bit settle down-counter: load value, decrement while enabled, flag at zero.
module det_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Parks at zero so a stray enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/det_matrix_loader.sv
// Serial front end of the 5x5 determinant unit. States: LOAD collects elements |
// SETTLE holds mat_flat while the determinant settles | OUT presents the captured result.
module det_matrix_loader
  import det_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N             = DEF_N,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic [N*N*DATA_W-1:0] mat_flat,
  input  logic [DATA_W-1:0]     det_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int         NUM_EL    = N * N;
  localparam int         IDX_W     = idx_w(NUM_EL);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [N*N*DATA_W-1:0]   mat_q;
  logic [DATA_W-1:0]       out_data_q;
  logic                    out_valid_q;
  logic                    frame_err_q;

  logic is_tail;
  logic accept;
  logic frame_done;
  logic tmr_zero;

  assign is_tail    = (idx_q == IDX_W'(NUM_EL - 1));
  assign accept     = (state_q == ST_LOAD) && in_valid;
  assign frame_done = accept && is_tail && in_last;

  det_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (frame_done),
    .load_val_i (SETTLE_LD),
    .en_i       (state_q == ST_SETTLE),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      mat_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            mat_q[int'(idx_q)*DATA_W +: DATA_W] <= in_data;
            if (is_tail && in_last) begin
              idx_q   <= '0;
              state_q <= ST_SETTLE;
            end else if (is_tail || in_last) begin
              // Malformed frame: keep what was written, restart at element 0.
              idx_q       <= '0;
              frame_err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            out_data_q  <= det_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_OUT);
  assign mat_flat  = mat_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed and randomized bench for det_matrix_loader with a permutation-sum determinant model.
module tb_det_matrix_loader;

  localparam int DW = 8;
  localparam int S  = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [199:0]  mat_flat;
  logic [DW-1:0] det_res;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cur [25];
  logic [7:0] mf  [25];
  logic [7:0] mat_snap [25];

  det_matrix_loader #(.DATA_W(DW), .N(5), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mat_flat  (mat_flat),
    .det_res   (det_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Determinant modulo 256 as a signed sum over all permutations of the columns.
  function automatic logic [7:0] det5(input logic [7:0] a [25]);
    int p [5];
    int acc;
    int prod;
    int inv;
    acc = 0;
    for (int i0 = 0; i0 < 5; i0++)
      for (int i1 = 0; i1 < 5; i1++)
        for (int i2 = 0; i2 < 5; i2++)
          for (int i3 = 0; i3 < 5; i3++)
            for (int i4 = 0; i4 < 5; i4++) begin
              p[0] = i0; p[1] = i1; p[2] = i2; p[3] = i3; p[4] = i4;
              if (((1 << i0) | (1 << i1) | (1 << i2) | (1 << i3) | (1 << i4)) == 31) begin
                prod = 1;
                for (int r = 0; r < 5; r++) prod = (prod * int'(a[r*5 + p[r]])) & 255;
                inv = 0;
                for (int i = 0; i < 5; i++)
                  for (int j = i + 1; j < 5; j++)
                    if (p[i] > p[j]) inv++;
                acc = (inv % 2 == 1) ? (acc - prod) & 255 : (acc + prod) & 255;
              end
            end
    return 8'(acc);
  endfunction

  // Stand-in for mod_det_5x5, driven from the DUT's assembled matrix.
  always_comb begin
    for (int k = 0; k < 25; k++) mf[k] = mat_flat[k*8 +: 8];
    det_res = det5(mf);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int k = 0; k < 25; k++) cur[k] = (k / 5 == k % 5) ? 8'd1 : 8'd0;
  endtask

  task automatic set_random();
    for (int k = 0; k < 25; k++) cur[k] = 8'($urandom);
  endtask

  // Send elements 0..n-1 of cur; in_last on element last_at (-1 for none).
  task automatic send(input int n, input int last_at, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(1) == 1) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end
      check("in_ready_load", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = cur[k];
      in_last  = (k == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_mat(input int n);
    for (int k = 0; k < n; k++) check($sformatf("mat_k%0d", k), mat_flat[k*8 +: 8], cur[k]);
  endtask

  // Called at E0+1ns; result must appear exactly S edges after the final accept.
  task automatic wait_result(input logic [7:0] exp, input bit junk);
    for (int i = 1; i <= S; i++) begin
      if (i < S) begin
        check("busy_settle", busy, 1'b1);
        check("in_ready_settle", in_ready, 1'b0);
        check("no_early_valid", out_valid, 1'b0);
      end
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid_at_S", out_valid, 1'b1);
    check("out_data", out_data, exp);
    check("busy_out", busy, 1'b1);
  endtask

  task automatic drain();
    check("in_ready_before_drain", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_after_drain", in_ready, 1'b1);
    check("busy_after_drain", busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_out_data", out_data, 8'd0);
    check("rst_mat_zero", {31'd0, |mat_flat}, 32'd0);

    // out_ready while idle is harmless
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_noeffect", out_valid, 1'b0);

    // Identity frame
    set_identity();
    send(25, 24, 1'b0);
    check_mat(25);
    wait_result(8'd1, 1'b0);
    drain();

    // Diagonal 2,1,1,1,3 with held backpressure and ignored input during SETTLE/OUT
    set_identity();
    cur[0] = 8'd2; cur[24] = 8'd3;
    send(25, 24, 1'b0);
    wait_result(8'd6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 8'd6);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check_mat(25);
    drain();

    // Early in_last on element 12
    set_random();
    send(13, 12, 1'b0);
    check("early_err_pulse", frame_err, 1'b1);
    check("early_no_busy", busy, 1'b0);
    check_mat(13);
    tick();
    check("early_err_clear", frame_err, 1'b0);
    set_identity();
    send(25, 24, 1'b0);
    wait_result(8'd1, 1'b0);
    drain();

    // Missing in_last on element 24
    set_random();
    send(25, -1, 1'b0);
    check("miss_err_pulse", frame_err, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("miss_err_clear", frame_err, 1'b0);
      check("miss_no_valid", out_valid, 1'b0);
      check("miss_in_ready", in_ready, 1'b1);
    end
    set_random();
    send(25, 24, 1'b0);
    wait_result(det5(cur), 1'b0);
    drain();

    // Two equal rows with random gaps
    set_random();
    for (int c = 0; c < 5; c++) cur[15 + c] = cur[5 + c];
    send(25, 24, 1'b1);
    check_mat(25);
    wait_result(8'd0, 1'b0);
    drain();

    // Random frames against the model
    for (int f = 0; f < 4; f++) begin
      set_random();
      send(25, 24, 1'b1);
      check_mat(25);
      wait_result(det5(cur), 1'b0);
      drain();
    end

    // Reset during SETTLE while the counter reads 2
    set_random();
    send(25, 24, 1'b0);
    tick();
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_mat_zero", {31'd0, |mat_flat}, 32'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_stale", out_valid, 1'b0);
    end
    set_identity();
    cur[6] = 8'd5;
    send(25, 24, 1'b0);
    wait_result(8'd5, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
